// File: rtl/sine_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sine_voice_scheduler
// Description : Shares one single-port sine ROM among VOICES phase-accumulator
//               voices, one ROM read per voice per sample frame, plus a mix.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_voice_scheduler #(
    parameter int VOICES  = 4,
    parameter int ROM_AW  = 16,
    parameter int PHASE_W = 32,
    parameter int MIX_W   = 16 + $clog2(VOICES)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      LOCKED,
    input  logic                      SAMPLE_TICK,
    input  logic                      FREQ_WE,
    input  logic [$clog2(VOICES)-1:0] FREQ_SEL,
    input  logic [PHASE_W-1:0]        FREQ_DATA,
    input  logic [VOICES-1:0]         GATE,
    output logic                      ROM_EN,
    output logic [ROM_AW-1:0]         ROM_ADDR,
    input  logic [15:0]               ROM_DATA,
    output logic [16*VOICES-1:0]      VOICE_OUT,
    output logic [MIX_W-1:0]          MIX_OUT,
    output logic                      MIX_VALID,
    output logic                      BUSY,
    output logic                      OVERRUN
);

    localparam int c_SEL_W = $clog2(VOICES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_SEL_W-1:0]   r_v;
    logic [PHASE_W-1:0]   r_phase [VOICES];
    logic [PHASE_W-1:0]   r_freq  [VOICES];
    logic [PHASE_W-1:0]   r_snap  [VOICES];
    logic [15:0]          r_shadow[VOICES];
    logic                 r_gate_q;
    logic [MIX_W-1:0]     r_acc;
    logic [MIX_W-1:0]     r_mix_out;
    logic [16*VOICES-1:0] r_voice_out;
    logic                 r_rom_en;
    logic [ROM_AW-1:0]    r_rom_addr;
    logic                 r_mix_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic [PHASE_W-1:0]   w_freq_next[VOICES];
    logic [c_SEL_W-1:0]   w_nv;
    logic [c_SEL_W-1:0]   w_iss_idx;
    logic [PHASE_W-1:0]   w_iss_freq;
    logic [PHASE_W-1:0]   w_iss_phase;
    logic                 w_last;
    logic                 w_do_issue;
    logic [15:0]          w_sample;

    // A write landing on the tick cycle must reach the frame snapshot.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_freq_next[i] = (FREQ_WE && (FREQ_SEL == c_SEL_W'(i))) ? FREQ_DATA : r_freq[i];
        end
    end

    assign w_last      = (r_v == c_SEL_W'(VOICES - 1));
    assign w_nv        = r_v + 1'b1;
    assign w_iss_idx   = (r_state == ST_IDLE) ? '0 : w_nv;
    assign w_iss_freq  = (r_state == ST_IDLE) ? w_freq_next[0] : r_snap[w_nv];
    assign w_iss_phase = r_phase[w_iss_idx] + w_iss_freq;
    assign w_do_issue  = LOCKED && (((r_state == ST_IDLE) && SAMPLE_TICK) ||
                                    ((r_state == ST_CAPTURE) && !w_last));
    assign w_sample    = r_gate_q ? ROM_DATA : 16'd0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_v         <= '0;
            r_gate_q    <= 1'b0;
            r_acc       <= '0;
            r_mix_out   <= '0;
            r_voice_out <= '0;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                r_phase[i]  <= '0;
                r_freq[i]   <= '0;
                r_snap[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                r_freq[i] <= w_freq_next[i];
            end
            r_rom_en    <= 1'b0;
            r_mix_valid <= 1'b0;
            if (SAMPLE_TICK && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (!LOCKED) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (SAMPLE_TICK) begin
                            r_state <= ST_ISSUE;
                            r_v     <= '0;
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                            for (int i = 0; i < VOICES; i++) begin
                                r_snap[i] <= w_freq_next[i];
                            end
                        end
                    end
                    ST_ISSUE: begin
                        r_state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        r_shadow[r_v] <= w_sample;
                        r_acc         <= r_acc + {{(MIX_W-16){w_sample[15]}}, w_sample};
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_v     <= w_nv;
                            r_state <= ST_ISSUE;
                        end
                    end
                    ST_DONE: begin
                        for (int i = 0; i < VOICES; i++) begin
                            r_voice_out[16*i +: 16] <= r_shadow[i];
                        end
                        r_mix_out   <= r_acc;
                        r_mix_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // The read is launched on entry so ROM data is back for CAPTURE.
            if (w_do_issue) begin
                if (GATE[w_iss_idx]) begin
                    r_phase[w_iss_idx] <= w_iss_phase;
                    r_rom_en           <= 1'b1;
                    r_rom_addr         <= w_iss_phase[PHASE_W-1 -: ROM_AW];
                    r_gate_q           <= 1'b1;
                end else begin
                    r_phase[w_iss_idx] <= '0;
                    r_gate_q           <= 1'b0;
                end
            end
        end
    end

    assign ROM_EN    = r_rom_en;
    assign ROM_ADDR  = r_rom_addr;
    assign VOICE_OUT = r_voice_out;
    assign MIX_OUT   = r_mix_out;
    assign MIX_VALID = r_mix_valid;
    assign BUSY      = r_busy;
    assign OVERRUN   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sine_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_voice_scheduler
// Description : Frame-level reference model plus directed scenarios for the
//               sine voice scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_voice_scheduler;

    localparam int V = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LOCKED = 1'b1;
    logic        SAMPLE_TICK = 1'b0;
    logic        FREQ_WE = 1'b0;
    logic [1:0]  FREQ_SEL = 2'd0;
    logic [31:0] FREQ_DATA = 32'd0;
    logic [3:0]  GATE = 4'd0;
    logic        ROM_EN;
    logic [15:0] ROM_ADDR;
    logic [15:0] ROM_DATA = 16'd0;
    logic [63:0] VOICE_OUT;
    logic [17:0] MIX_OUT;
    logic        MIX_VALID;
    logic        BUSY;
    logic        OVERRUN;

    always #5 CLK = ~CLK;

    sine_voice_scheduler #(
        .VOICES (4),
        .ROM_AW (16),
        .PHASE_W(32),
        .MIX_W  (18)
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .LOCKED     (LOCKED),
        .SAMPLE_TICK(SAMPLE_TICK),
        .FREQ_WE    (FREQ_WE),
        .FREQ_SEL   (FREQ_SEL),
        .FREQ_DATA  (FREQ_DATA),
        .GATE       (GATE),
        .ROM_EN     (ROM_EN),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .VOICE_OUT  (VOICE_OUT),
        .MIX_OUT    (MIX_OUT),
        .MIX_VALID  (MIX_VALID),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    int rom_mode = 0;

    function automatic logic [15:0] romf(input int mode, input logic [15:0] a);
        case (mode)
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            default: return {a[7:0], a[15:8]} ^ 16'h1234;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (ROM_EN) ROM_DATA <= romf(rom_mode, ROM_ADDR);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: everything about a frame is decided when its tick is accepted.
    logic [31:0] m_phase[V], m_freq[V], m_np[V];
    logic [15:0] m_addr[V], m_samp[V];
    logic        m_g[V];
    logic [17:0] m_mix_frame;
    logic        m_active, m_en, m_mv, m_ov;
    logic [15:0] m_addr_hold;
    logic [63:0] m_vout;
    logic [17:0] m_mix;
    int          m_start, cyc, last_tick_cyc, last_lat, mv_count;
    logic [15:0] addr_log[$];

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_phase[i] = '0;
            m_freq[i]  = '0;
        end
        m_active = 1'b0; m_en = 1'b0; m_mv = 1'b0; m_ov = 1'b0;
        m_addr_hold = '0; m_vout = '0; m_mix = '0;
    endtask

    task automatic model_issue(input int v);
        m_phase[v] = m_np[v];
        if (m_g[v]) begin
            m_en = 1'b1;
            m_addr_hold = m_addr[v];
        end
    endtask

    task automatic model_step();
        int k;
        int sum;
        cyc++;
        m_mv = 1'b0;
        m_en = 1'b0;
        if (FREQ_WE) m_freq[FREQ_SEL] = FREQ_DATA;
        if (SAMPLE_TICK) last_tick_cyc = cyc;
        if (!m_active) begin
            if (SAMPLE_TICK && LOCKED) begin
                m_active = 1'b1;
                m_start = cyc;
                sum = 0;
                for (int v = 0; v < V; v++) begin
                    m_g[v]    = GATE[v];
                    m_np[v]   = GATE[v] ? m_phase[v] + m_freq[v] : 32'd0;
                    m_addr[v] = m_np[v][31:16];
                    m_samp[v] = GATE[v] ? romf(rom_mode, m_addr[v]) : 16'd0;
                    sum += $signed(m_samp[v]);
                end
                m_mix_frame = sum[17:0];
                model_issue(0);
            end
        end else begin
            k = cyc - m_start;
            if (SAMPLE_TICK) m_ov = 1'b1;
            if (!LOCKED) begin
                m_active = 1'b0;
            end else if (k == 2*V + 1) begin
                m_mv = 1'b1;
                m_mix = m_mix_frame;
                for (int v = 0; v < V; v++) m_vout[16*v +: 16] = m_samp[v];
                m_active = 1'b0;
            end else if ((k % 2 == 0) && (k < 2*V)) begin
                model_issue(k / 2);
            end
        end
    endtask

    initial begin
        cyc = 0; last_tick_cyc = 0; last_lat = -1; mv_count = 0;
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RST_N) model_reset(); else model_step();
            @(negedge CLK);
            if (!RST_N) model_reset();
            check("rom_en",    ROM_EN,    m_en);
            check("rom_addr",  ROM_ADDR,  m_addr_hold);
            check("busy",      BUSY,      m_active);
            check("mix_valid", MIX_VALID, m_mv);
            check("mix_out",   MIX_OUT,   m_mix);
            check("voice_out", VOICE_OUT, m_vout);
            check("overrun",   OVERRUN,   m_ov);
            if (ROM_EN) addr_log.push_back(ROM_ADDR);
            if (MIX_VALID) begin
                mv_count++;
                last_lat = cyc - last_tick_cyc;
            end
        end
    end

    function automatic logic [15:0] logat(input int i);
        if (i < addr_log.size()) return addr_log[i];
        return 'x;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick();
        @(negedge CLK); #1 SAMPLE_TICK = 1'b1;
        @(negedge CLK); #1 SAMPLE_TICK = 1'b0;
    endtask

    task automatic wfreq(input logic [1:0] s, input logic [31:0] d, input logic with_tick);
        @(negedge CLK); #1;
        FREQ_WE = 1'b1; FREQ_SEL = s; FREQ_DATA = d; SAMPLE_TICK = with_tick;
        @(negedge CLK); #1;
        FREQ_WE = 1'b0; SAMPLE_TICK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int mv0;

    initial begin
        idle(2); #2;
        check("reset_busy", BUSY, 0);
        check("reset_rom_en", ROM_EN, 0);
        #1 RST_N = 1'b1;

        // Single voice stepping 0x0100 per frame
        wfreq(2'd0, 32'h0100_0000, 1'b0);
        GATE = 4'b0001; rom_mode = 0;
        addr_log.delete();
        repeat (3) begin tick(); idle(12); end
        check("t2_nreads", addr_log.size(), 3);
        check("t2_addr0", logat(0), 16'h0100);
        check("t2_addr1", logat(1), 16'h0200);
        check("t2_addr2", logat(2), 16'h0300);
        check("t2_latency", last_lat, 9);
        check("t2_mix", MIX_OUT, 18'h01237);
        check("t2_voice0", VOICE_OUT[15:0], 16'h1237);

        // Full-scale mix in both polarities, with a write on the tick cycle
        wfreq(2'd1, 32'h0123_4567, 1'b0);
        wfreq(2'd2, 32'h0FED_CBA9, 1'b0);
        wfreq(2'd3, 32'h3000_0001, 1'b0);
        GATE = 4'hF; rom_mode = 1;
        tick(); idle(12);
        check("t3_mix_pos", MIX_OUT, 18'h1FFFC);
        rom_mode = 2;
        wfreq(2'd3, 32'h0000_1000, 1'b1); idle(12);
        check("t3_mix_neg", MIX_OUT, 18'h20000);

        // Gate-off frame clears phases, then wrap from 0x8000_0000
        GATE = 4'h0; rom_mode = 0;
        tick(); idle(12);
        wfreq(2'd0, 32'h8000_0000, 1'b0);
        GATE = 4'b0001;
        addr_log.delete();
        tick(); idle(12);
        tick(); idle(12);
        check("t4_nreads", addr_log.size(), 2);
        check("t4_addr_half", logat(0), 16'h8000);
        check("t4_addr_wrap", logat(1), 16'h0000);

        // Clock loss while voice 2 is being issued
        GATE = 4'b0111;
        mv0 = mv_count;
        tick();
        idle(4); #1;
        check("t6_issue2_rom_en", ROM_EN, 1);
        LOCKED = 1'b0;
        @(negedge CLK); #2;
        check("t6_abort_rom_en", ROM_EN, 0);
        check("t6_abort_busy", BUSY, 0);
        tick(); idle(3);
        check("t6_unlocked_overrun", OVERRUN, 0);
        check("t6_unlocked_busy", BUSY, 0);
        #1 LOCKED = 1'b1;
        idle(12);
        check("t6_no_mix_valid", mv_count, mv0);
        tick(); idle(12);
        check("t6_recovery_frame", mv_count, mv0 + 1);

        // Tick arriving four cycles into a frame
        check("t5_overrun_before", OVERRUN, 0);
        mv0 = mv_count;
        tick(); idle(2); tick(); idle(14);
        check("t5_overrun_set", OVERRUN, 1);
        check("t5_one_mix_valid", mv_count, mv0 + 1);
        tick(); idle(12);
        check("t5_overrun_sticky", OVERRUN, 1);

        // Asynchronous reset in the middle of a frame
        GATE = 4'hF;
        tick(); idle(1);
        #2 RST_N = 1'b0;
        #1;
        check("t1_rom_en", ROM_EN, 0);
        check("t1_rom_addr", ROM_ADDR, 0);
        check("t1_busy", BUSY, 0);
        check("t1_mix_valid", MIX_VALID, 0);
        check("t1_overrun", OVERRUN, 0);
        check("t1_mix_out", MIX_OUT, 0);
        check("t1_voice_out", VOICE_OUT, 0);
        idle(2); #1 RST_N = 1'b1;
        idle(3);
        check("t1_idle_after_release", BUSY, 0);
        wfreq(2'd0, 32'h0100_0000, 1'b0);
        GATE = 4'b0001;
        addr_log.delete();
        tick(); idle(12);
        check("t1_addr_restart", logat(0), 16'h0100);
        check("t1_latency", last_lat, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
